// File: rtl/audio_sd_dac_mixer_pkg.sv
// audio_pkg: shared constants, sample type and attenuation helper for the
// audio output stage (audio_sd_dac_mixer and audio_sd_modulator).
//   SAMPLE_W  : width of one signed audio sample
//   MIX_W     : width of the mixer sum (two guard bits)
//   MIDSCALE  : offset-binary silence level driven into the modulator
//   CLAMP_MAX / CLAMP_MIN : saturation limits of the mixer sum
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned MIX_W    = 18;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  localparam logic signed [MIX_W-1:0] CLAMP_MAX = 18'sd32767;
  localparam logic signed [MIX_W-1:0] CLAMP_MIN = -18'sd32768;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [MIX_W-1:0]    mix_t;

  // Volume 7 passes the sample unchanged, each step down halves it,
  // volume 0 mutes the source completely.
  function automatic sample_t attenuate(input sample_t x, input logic [2:0] vol);
    if (vol == 3'd0) begin
      return '0;
    end
    return x >>> (3'd7 - vol);
  endfunction

endpackage

// File: rtl/audio_sd_dac_mixer_modulator.sv
// audio_sd_modulator: delta-sigma modulator turning a 16-bit offset-binary
// target into a 1-bit stream, updated every clk_vga cycle.
//   clk_vga    : DAC clock
//   reset_wire : asynchronous, active-high reset
//   target     : offset-binary level, 0x8000 = silence
//   bit_out    : registered modulator output
// Build option: AUDIO_DAC_2ND_ORDER_EN selects a second-order error-feedback
// loop; otherwise a first-order accumulator is used.
module audio_sd_modulator
  import audio_pkg::*;
#(
  parameter int unsigned ACC_W = 17
) (
  input  logic                clk_vga,
  input  logic                reset_wire,
  input  logic [SAMPLE_W-1:0] target,
  output logic                bit_out
);

`ifdef AUDIO_DAC_2ND_ORDER_EN

  localparam int unsigned I_W = 20;
  localparam int unsigned E_W = I_W + 2;

  localparam logic signed [E_W-1:0] SAT_POS = 22'sd262144;
  localparam logic signed [E_W-1:0] SAT_NEG = -22'sd262144;

  logic signed [I_W-1:0] i1_q, i2_q;
  logic                  out_q;
  logic signed [E_W-1:0] u, fb, i1_sum, i2_sum;
  logic signed [I_W-1:0] i1_next, i2_next;

  function automatic logic signed [I_W-1:0] sat_int(input logic signed [E_W-1:0] v);
    if (v > SAT_POS) begin
      return I_W'(SAT_POS);
    end
    if (v < SAT_NEG) begin
      return I_W'(SAT_NEG);
    end
    return v[I_W-1:0];
  endfunction

  always_comb begin
    u       = $signed({6'b0, target}) - 22'sd32768;
    fb      = out_q ? 22'sd32768 : -22'sd32768;
    i1_sum  = {{2{i1_q[I_W-1]}}, i1_q} + u - fb;
    i2_sum  = {{2{i2_q[I_W-1]}}, i2_q} + {{2{i1_q[I_W-1]}}, i1_q} - fb;
    i1_next = sat_int(i1_sum);
    i2_next = sat_int(i2_sum);
  end

  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      i1_q  <= '0;
      i2_q  <= '0;
      out_q <= 1'b0;
    end else begin
      i1_q  <= i1_next;
      i2_q  <= i2_next;
      out_q <= ~i2_q[I_W-1];
    end
  end

  assign bit_out = out_q;

`else

  logic [ACC_W-1:0] acc_q;

  // The carry out of the 16-bit sum is the output bit; it is dropped before
  // the next addition so the long-run ones density equals target / 65536.
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      acc_q <= '0;
    end else begin
      acc_q <= {1'b0, acc_q[ACC_W-2:0]} + ACC_W'(target);
    end
  end

  assign bit_out = acc_q[ACC_W-1];

`endif

endmodule

// File: rtl/audio_sd_dac_mixer.sv
// audio_sd_dac_mixer: output audio stage. Synchronises the OPL2, Tandy PSG and
// PC speaker sources from clk_chipset, captures them at a fixed sample tick,
// attenuates, mixes with saturation and feeds a delta-sigma DAC on aud_l/aud_r.
//   clk_vga      : audio/DAC clock (28.636 MHz)
//   reset_wire   : asynchronous, active-high reset
//   opl2_in      : signed OPL2 sample (clk_chipset domain)
//   tandy_in     : signed Tandy PSG sample (clk_chipset domain)
//   speaker_in   : PC speaker bit (asynchronous)
//   vol_opl2/vol_tandy/vol_spk : 0 = mute .. 7 = full, quasi-static
//   mute         : forces the DAC target to midscale from the next sample
//   clip_clr     : clears clip_sticky
//   aud_l/aud_r  : identical delta-sigma bitstreams
//   clip_sticky  : set when the mixer saturates
//   sample_tick  : one-cycle pulse per sample period
// Build option: AUDIO_DAC_2ND_ORDER_EN selects the second-order modulator.
module audio_sd_dac_mixer
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 596,
  parameter int          SPK_LEVEL  = 8192,
  parameter int unsigned ACC_W      = 17
) (
  input  logic                clk_vga,
  input  logic                reset_wire,
  input  logic [SAMPLE_W-1:0] opl2_in,
  input  logic [SAMPLE_W-1:0] tandy_in,
  input  logic                speaker_in,
  input  logic [2:0]          vol_opl2,
  input  logic [2:0]          vol_tandy,
  input  logic [2:0]          vol_spk,
  input  logic                mute,
  input  logic                clip_clr,
  output logic                aud_l,
  output logic                aud_r,
  output logic                clip_sticky,
  output logic                sample_tick
);

  localparam int unsigned CNT_W    = $clog2(SAMPLE_DIV);
  localparam sample_t     SPK_FULL = sample_t'(SPK_LEVEL);

  logic [CNT_W-1:0] tick_cnt;

  sample_t opl2_s1, opl2_s2, opl2_prev;
  sample_t tandy_s1, tandy_s2, tandy_prev;
  logic    spk_s1, spk_s2, spk_prev;

  sample_t cap_opl2, cap_tandy;
  logic    cap_spk;

  sample_t a_opl2, a_tandy, a_spk;
  logic    v_a, v_m, v_t;

  mix_t    mix_sum;
  logic    clamp_hi, clamp_lo;
  sample_t mix_sat;
  sample_t mix_q;

  logic [SAMPLE_W-1:0] dac_target;
  logic                sd_bit;

  // Sample tick counter
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign sample_tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

  // Two-flop synchronisers plus one history register per source; the bus
  // sources are only trusted when sync2 agrees with the previous cycle, which
  // rejects a word caught half-way through a multi-bit change.
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      opl2_s1    <= '0;
      opl2_s2    <= '0;
      opl2_prev  <= '0;
      tandy_s1   <= '0;
      tandy_s2   <= '0;
      tandy_prev <= '0;
      spk_s1     <= 1'b0;
      spk_s2     <= 1'b0;
      spk_prev   <= 1'b0;
    end else begin
      opl2_s1    <= opl2_in;
      opl2_s2    <= opl2_s1;
      opl2_prev  <= opl2_s2;
      tandy_s1   <= tandy_in;
      tandy_s2   <= tandy_s1;
      tandy_prev <= tandy_s2;
      spk_s1     <= speaker_in;
      spk_s2     <= spk_s1;
      spk_prev   <= spk_s2;
    end
  end

  // Stage C: capture on the tick, each source judged on its own stability
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      cap_opl2  <= '0;
      cap_tandy <= '0;
      cap_spk   <= 1'b0;
    end else if (sample_tick) begin
      if (opl2_s2 == opl2_prev) begin
        cap_opl2 <= opl2_s2;
      end
      if (tandy_s2 == tandy_prev) begin
        cap_tandy <= tandy_s2;
      end
      if (spk_s2 == spk_prev) begin
        cap_spk <= spk_s2;
      end
    end
  end

  // Stage valid strobes following the tick through A, M and target
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      v_a <= 1'b0;
      v_m <= 1'b0;
      v_t <= 1'b0;
    end else begin
      v_a <= sample_tick;
      v_m <= v_a;
      v_t <= v_m;
    end
  end

  // Stage A: attenuation
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      a_opl2  <= '0;
      a_tandy <= '0;
      a_spk   <= '0;
    end else if (v_a) begin
      a_opl2  <= attenuate(cap_opl2, vol_opl2);
      a_tandy <= attenuate(cap_tandy, vol_tandy);
      a_spk   <= cap_spk ? attenuate(SPK_FULL, vol_spk) : '0;
    end
  end

  // Stage M: mix at 18 bits (OPL2 weighted x2), then saturate to 16 bits
  always_comb begin
    mix_sum  = ({{2{a_opl2[SAMPLE_W-1]}}, a_opl2} <<< 1)
             + {{2{a_tandy[SAMPLE_W-1]}}, a_tandy}
             + {{2{a_spk[SAMPLE_W-1]}}, a_spk};
    clamp_hi = (mix_sum > CLAMP_MAX);
    clamp_lo = (mix_sum < CLAMP_MIN);
    if (clamp_hi) begin
      mix_sat = 16'sh7FFF;
    end else if (clamp_lo) begin
      mix_sat = 16'sh8000;
    end else begin
      mix_sat = mix_sum[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      mix_q <= '0;
    end else if (v_m) begin
      mix_q <= mix_sat;
    end
  end

  // A clamp in the same cycle as clip_clr wins so no clip event is lost
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      clip_sticky <= 1'b0;
    end else if (v_m && (clamp_hi || clamp_lo)) begin
      clip_sticky <= 1'b1;
    end else if (clip_clr) begin
      clip_sticky <= 1'b0;
    end
  end

  // DAC target: signed to offset binary, mute applied with the sample
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      dac_target <= MIDSCALE;
    end else if (v_t) begin
      dac_target <= mute ? MIDSCALE : {~mix_q[SAMPLE_W-1], mix_q[SAMPLE_W-2:0]};
    end
  end

  audio_sd_modulator #(
    .ACC_W (ACC_W)
  ) u_mod (
    .clk_vga    (clk_vga),
    .reset_wire (reset_wire),
    .target     (dac_target),
    .bit_out    (sd_bit)
  );

  assign aud_l = sd_bit;
  assign aud_r = sd_bit;

endmodule
